// File: rtl/uart_pkg.sv
// Shared definitions for the uart_rx receiver and its sequencer: FSM encoding and bit-time arithmetic.
package uart_pkg;

   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned DROP_MAX = 255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_DATA,
      ST_WAIT_END,
      ST_COMMIT,
      ST_ABORT
   } rx_state_e;

   function automatic int unsigned cycles_per_bit(input int unsigned clk_hz, input int unsigned baud);
      return clk_hz / baud;
   endfunction

   function automatic int unsigned watchdog_limit(input int unsigned clk_hz, input int unsigned baud,
                                                  input int unsigned bits);
      return bits * cycles_per_bit(clk_hz, baud);
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Valid/ready byte stream carrying received data out of uart_rx_ctrl.
interface uart_rx_ctrl_if;
   import uart_pkg::*;

   logic [BYTE_W-1:0] m_data_o;
   logic              m_valid_o;
   logic              m_ready_i;

   modport master (output m_data_o, output m_valid_o, input m_ready_i);
   modport slave  (input m_data_o, input m_valid_o, output m_ready_i);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO; head byte reads as zero while empty.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned p_depth = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic [BYTE_W-1:0]        data_i,
   input  logic                     pop_i,
   output logic [BYTE_W-1:0]        data_o,
   output logic [$clog2(p_depth):0] level_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int unsigned AW = $clog2(p_depth);
   localparam int unsigned LW = AW + 1;

   logic [BYTE_W-1:0] mem_q [p_depth];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              push_ok, pop_ok;

   always_comb begin
      full_o   = (level_q == LW'(p_depth));
      empty_o  = (level_q == '0);
      push_ok  = push_i & ~full_o;
      pop_ok   = pop_i & ~empty_o;
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      if (push_ok && !pop_ok) begin
         level_d = level_q + LW'(1);
      end else if (pop_ok && !push_ok) begin
         level_d = level_q - LW'(1);
      end
      data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
      level_o = level_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: the head is masked while empty.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer for one uart_rx: gates its enable on FIFO room, applies config between frames,
// judges each frame after it ends, and forwards good bytes through a FWFT FIFO.
//
// state         | meaning
// ST_IDLE       | between frames; enable allowed when FIFO has room, config may load
// ST_WAIT_DATA  | start accepted by uart_rx, waiting for the byte
// ST_WAIT_END   | byte held, collecting error flags until the frame ends
// ST_COMMIT     | push a clean byte, or count a bad frame
// ST_ABORT      | watchdog expired; pulse uart_rx reset and count the loss
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned p_clk_speed_hz = 50_000_000,
   parameter int unsigned p_baud_rate    = 9_600,
   parameter int unsigned p_fifo_depth   = 8,
   parameter int unsigned p_timeout_bits = 12
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          en_i,
   input  logic                          parity_en_i,
   input  logic                          parity_sel_i,
   input  logic                          clr_i,
   output logic                          rx_rst_n_o,
   output logic                          rx_enable_o,
   output logic                          rx_parity_en_o,
   output logic                          rx_parity_sel_o,
   input  logic [BYTE_W-1:0]             rx_data_i,
   input  logic                          rx_busy_i,
   input  logic                          rx_data_ready_i,
   input  logic                          rx_parity_err_i,
   input  logic                          rx_framing_err_i,
   uart_rx_ctrl_if.master                m_if,
   output logic [$clog2(p_fifo_depth):0] level_o,
   output logic [7:0]                    drop_cnt_o,
   output logic [1:0]                    err_flags_o,
   output logic                          timeout_o
);
   localparam int unsigned LIMIT = watchdog_limit(p_clk_speed_hz, p_baud_rate, p_timeout_bits);
   localparam int unsigned TW    = $clog2(LIMIT + 1);

   rx_state_e         state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              dr_q, dr_d, run_q, run_d;
   logic [BYTE_W-1:0] hold_q, hold_d;
   logic [1:0]        err_acc_q, err_acc_d;
   logic              par_en_q, par_en_d, par_sel_q, par_sel_d;
   logic [7:0]        drop_q, drop_d;
   logic [1:0]        flags_q, flags_d;
   logic              timeout_q, timeout_d;
   logic              dr_rise, tmo, push, drop_inc;
   logic              fifo_full, fifo_empty;

   uart_rx_fifo #(.p_depth(p_fifo_depth)) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push),
      .data_i  (hold_q),
      .pop_i   (m_if.m_ready_i),
      .data_o  (m_if.m_data_o),
      .level_o (level_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign m_if.m_valid_o = ~fifo_empty;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q - TW'(1);
      dr_d      = rx_data_ready_i;
      run_d     = 1'b1;
      hold_d    = hold_q;
      err_acc_d = err_acc_q;
      par_en_d  = par_en_q;
      par_sel_d = par_sel_q;
      push      = 1'b0;
      dr_rise   = rx_data_ready_i & ~dr_q;
      tmo       = (timer_q == '0);

      unique case (state_q)
         ST_IDLE: begin
            timer_d = TW'(LIMIT - 1);
            if (rx_busy_i) begin
               state_d = ST_WAIT_DATA;
            end else begin
               par_en_d  = parity_en_i;
               par_sel_d = parity_sel_i;
            end
         end
         ST_WAIT_DATA: begin
            if (dr_rise) begin
               hold_d    = rx_data_i;
               err_acc_d = '0;
               state_d   = ST_WAIT_END;
            end else if (!rx_busy_i) begin
               state_d = ST_IDLE;
            end else if (tmo) begin
               state_d = ST_ABORT;
            end
         end
         ST_WAIT_END: begin
            err_acc_d = err_acc_q | {rx_framing_err_i, rx_parity_err_i};
            if (!rx_busy_i) begin
               state_d = ST_COMMIT;
            end else if (tmo) begin
               state_d = ST_ABORT;
            end
         end
         ST_COMMIT: begin
            push    = (err_acc_q == '0);
            state_d = ST_IDLE;
         end
         ST_ABORT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // A clean byte meeting a full FIFO is lost like a bad frame.
      drop_inc  = ((state_q == ST_COMMIT) && ((err_acc_q != '0) || fifo_full)) || (state_q == ST_ABORT);
      drop_d    = clr_i ? '0 : ((drop_inc && (drop_q != 8'(DROP_MAX))) ? drop_q + 8'd1 : drop_q);
      flags_d   = clr_i ? '0 : ((state_q == ST_COMMIT) ? (flags_q | err_acc_q) : flags_q);
      timeout_d = clr_i ? 1'b0 : (timeout_q | (state_q == ST_ABORT));

      rx_rst_n_o      = run_q & (state_q != ST_ABORT);
      rx_enable_o     = run_q & (state_q == ST_IDLE) & en_i & ~fifo_full;
      rx_parity_en_o  = par_en_q;
      rx_parity_sel_o = par_sel_q;
      drop_cnt_o      = drop_q;
      err_flags_o     = flags_q;
      timeout_o       = timeout_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         dr_q      <= 1'b0;
         run_q     <= 1'b0;
         hold_q    <= '0;
         err_acc_q <= '0;
         par_en_q  <= 1'b0;
         par_sel_q <= 1'b0;
         drop_q    <= '0;
         flags_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         dr_q      <= dr_d;
         run_q     <= run_d;
         hold_q    <= hold_d;
         err_acc_q <= err_acc_d;
         par_en_q  <= par_en_d;
         par_sel_q <= par_sel_d;
         drop_q    <= drop_d;
         flags_q   <= flags_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a transaction-level uart_rx peer drives frames, a scoreboard queue
// holds the bytes that should come out, and a monitor compares every accepted output byte.
module tb_uart_rx_ctrl;
   localparam int unsigned CLK_HZ   = 1_000_000;
   localparam int unsigned BAUD     = 100_000;
   localparam int unsigned DEPTH    = 8;
   localparam int unsigned TBITS    = 12;
   localparam int unsigned WD_LIMIT = TBITS * (CLK_HZ / BAUD);
   localparam int unsigned LVW      = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1, par_en = 1'b0, par_sel = 1'b0, clr = 1'b0;
   logic rx_rst_n_o, rx_enable_o, rx_parity_en_o, rx_parity_sel_o;
   logic [7:0] rx_data = '0;
   logic rx_busy = 1'b0, rx_dr = 1'b0, rx_pe = 1'b0, rx_fe = 1'b0;
   logic m_ready;
   logic [LVW-1:0] level;
   logic [7:0] drop_cnt;
   logic [1:0] err_flags;
   logic timeout;

   int checks = 0;
   int failures = 0;
   int rdy_mode = 0;
   logic [7:0] exp_q[$];
   int exp_drop = 0;
   int exp_flags = 0;
   int exp_timeout = 0;
   logic [7:0] mon_exp;

   uart_rx_ctrl_if m_if ();
   assign m_if.m_ready_i = m_ready;

   always #5 clk = ~clk;

   uart_rx_ctrl #(
      .p_clk_speed_hz (CLK_HZ),
      .p_baud_rate    (BAUD),
      .p_fifo_depth   (DEPTH),
      .p_timeout_bits (TBITS)
   ) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .en_i             (en),
      .parity_en_i      (par_en),
      .parity_sel_i     (par_sel),
      .clr_i            (clr),
      .rx_rst_n_o       (rx_rst_n_o),
      .rx_enable_o      (rx_enable_o),
      .rx_parity_en_o   (rx_parity_en_o),
      .rx_parity_sel_o  (rx_parity_sel_o),
      .rx_data_i        (rx_data),
      .rx_busy_i        (rx_busy),
      .rx_data_ready_i  (rx_dr),
      .rx_parity_err_i  (rx_pe),
      .rx_framing_err_i (rx_fe),
      .m_if             (m_if.master),
      .level_o          (level),
      .drop_cnt_o       (drop_cnt),
      .err_flags_o      (err_flags),
      .timeout_o        (timeout)
   );

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   function automatic int sat_inc(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_drop"}, drop_cnt, exp_drop);
      chk({tag, "_flags"}, err_flags, exp_flags);
      chk({tag, "_timeout"}, timeout, exp_timeout);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_rx_rst_n"}, rx_rst_n_o, 0);
      chk({tag, "_rx_enable"}, rx_enable_o, 0);
      chk({tag, "_rx_par"}, {rx_parity_en_o, rx_parity_sel_o}, 0);
      chk({tag, "_m_valid"}, m_if.m_valid_o, 0);
      chk({tag, "_m_data"}, m_if.m_data_o, 0);
      chk({tag, "_level"}, level, 0);
      chk({tag, "_drop"}, drop_cnt, 0);
      chk({tag, "_flags"}, err_flags, 0);
      chk({tag, "_timeout"}, timeout, 0);
   endtask

   task automatic clear_model();
      exp_q.delete();
      exp_drop = 0;
      exp_flags = 0;
      exp_timeout = 0;
   endtask

   task automatic release_reset();
      rx_busy = 1'b0; rx_dr = 1'b0; rx_pe = 1'b0; rx_fe = 1'b0; clr = 1'b0;
      nclk(2);
      rst_n = 1'b1;
      nclk(1);
      chk("rx_rst_n_after_release", rx_rst_n_o, 1);
   endtask

   task automatic wait_enable(output bit ok);
      int n = 0;
      @(negedge clk);
      while (!rx_enable_o && n < 400) begin
         @(negedge clk);
         n++;
      end
      ok = rx_enable_o;
      if (!ok) bound_fail("enable_wait");
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || m_if.m_valid_o) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0 || m_if.m_valid_o) bound_fail(name);
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_drop = 0;
      exp_flags = 0;
      exp_timeout = 0;
      nclk(1);
   endtask

   // One frame as uart_rx would present it: busy, later the byte with its error flags, then busy low.
   task automatic send_frame(input logic [7:0] d, input bit pe, input bit fe, input int len,
                             input bit en_drop, input bit clr_at_commit);
      bit ok;
      wait_enable(ok);
      if (!ok) return;
      rx_busy = 1'b1; rx_dr = 1'b0; rx_pe = 1'b0; rx_fe = 1'b0;
      if (!pe && !fe) begin
         exp_q.push_back(d);
      end else begin
         exp_drop = sat_inc(exp_drop);
         exp_flags = exp_flags | {fe, pe};
      end
      if (en_drop) begin
         nclk(1);
         en = 1'b0;
      end
      nclk(len);
      rx_data = d; rx_dr = 1'b1; rx_pe = pe; rx_fe = fe;
      nclk(3);
      rx_busy = 1'b0;
      if (clr_at_commit) begin
         @(negedge clk);
         clr = 1'b1;
         @(negedge clk);
         clr = 1'b0;
         exp_drop = 0;
         exp_flags = 0;
         exp_timeout = 0;
         nclk(2);
      end else begin
         nclk(4);
      end
      en = 1'b1;
   endtask

   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && m_if.m_valid_o && m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_byte: got %0d expected none", m_if.m_data_o);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("m_data", m_if.m_data_o, mon_exp);
            end
         end
      end
   end

   initial begin
      #600_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      bit ok;
      int first_low, low_cnt;
      logic old_par;

      nclk(1);
      check_zero_outputs("reset");
      release_reset();

      // Parity off, two clean bytes.
      rdy_mode = 1;
      send_frame(8'hA5, 0, 0, 80, 0, 0);
      send_frame(8'h3C, 0, 0, 80, 0, 0);
      wait_drain("drain_t1");
      check_status("t1");

      // Even parity, one bad frame then a good one.
      par_en = 1'b1; par_sel = 1'b1;
      nclk(2);
      chk("cfg_par_en", rx_parity_en_o, 1);
      chk("cfg_par_sel", rx_parity_sel_o, 1);
      send_frame(8'h01, 1, 0, 80, 0, 0);
      chk("t2_no_valid", m_if.m_valid_o, 0);
      check_status("t2");
      send_frame(8'h02, 0, 0, 80, 0, 0);
      wait_drain("drain_t2");

      // Framing error, then clear.
      clr_pulse();
      send_frame(8'h55, 0, 1, 80, 0, 0);
      check_status("t3");
      clr_pulse();
      check_status("t3_clr");

      // Fill the FIFO with the sink stalled.
      rdy_mode = 0;
      for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 0, 0, 80, 0, 0);
      chk("t4_level_full", level, DEPTH);
      chk("t4_enable_full", rx_enable_o, 0);
      low_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rx_enable_o) low_cnt++;
      end
      chk("t4_enable_blocked", low_cnt, 0);
      check_status("t4");
      rdy_mode = 1;
      nclk(1);
      rdy_mode = 0;
      nclk(1);
      chk("t4_level_after_pop", level, DEPTH - 1);
      chk("t4_enable_after_pop", rx_enable_o, 1);
      rdy_mode = 2;
      wait_drain("drain_t4");

      // Random traffic, random sink stalls, occasional en_i drop mid-frame.
      for (int i = 0; i < 25; i++) begin
         send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(20, 90), $urandom_range(0, 3) == 0, 0);
      end
      wait_drain("drain_random");
      check_status("random");

      // Bad frame whose count increment coincides with clr_i: the clear wins.
      send_frame(8'h77, 1, 1, 30, 0, 1);
      check_status("clr_vs_inc");

      // Watchdog: busy held far longer than a frame. The busy edge is seen on the first clock,
      // the watchdog then runs its full limit in WAIT_DATA, and ABORT follows on the next clock.
      wait_enable(ok);
      rx_busy = 1'b1; rx_dr = 1'b0; rx_pe = 1'b0; rx_fe = 1'b0;
      first_low = 0;
      low_cnt = 0;
      for (int i = 1; i <= 130; i++) begin
         @(negedge clk);
         if (!rx_rst_n_o) begin
            if (low_cnt == 0) first_low = i;
            low_cnt++;
         end
      end
      rx_busy = 1'b0;
      exp_drop = sat_inc(exp_drop);
      exp_timeout = 1;
      nclk(4);
      chk("wd_abort_clk", first_low, WD_LIMIT + 1);
      chk("wd_rst_pulse_len", low_cnt, 1);
      chk("wd_no_valid", m_if.m_valid_o, 0);
      check_status("wd");

      // Parity enable changed mid-frame is held until the frame is over.
      rdy_mode = 0;
      old_par = rx_parity_en_o;
      wait_enable(ok);
      rx_busy = 1'b1; rx_dr = 1'b0; rx_pe = 1'b0; rx_fe = 1'b0;
      exp_q.push_back(8'h6B);
      nclk(3);
      par_en = ~old_par;
      nclk(5);
      chk("par_held_mid_frame", rx_parity_en_o, old_par);
      rx_data = 8'h6B; rx_dr = 1'b1;
      nclk(3);
      rx_busy = 1'b0;
      nclk(6);
      chk("par_applied_after_frame", rx_parity_en_o, !old_par);
      chk("level_before_reset", level, exp_q.size());

      // Asynchronous reset in the middle of a frame.
      wait_enable(ok);
      rx_busy = 1'b1; rx_dr = 1'b0;
      nclk(20);
      rst_n = 1'b0;
      #1;
      check_zero_outputs("mid_reset");
      clear_model();
      release_reset();

      // Drop counter saturation.
      rdy_mode = 2;
      for (int i = 0; i < 260; i++) send_frame(8'(i), 0, 1, 2, 0, 0);
      check_status("saturate");
      send_frame(8'hC3, 0, 0, 40, 0, 0);
      wait_drain("drain_final");
      chk("final_level", level, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
